// File: rtl/wb_register_file_if.sv
// Writeback, issue and read-port bundle for wb_register_file.
interface wb_register_file_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] result_in;
   logic [ADDR_WIDTH-1:0] reg_addr_in;
   logic                  write_enable_in;
   logic                  issue_valid;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic [ADDR_WIDTH-1:0] rs1_addr;
   logic [ADDR_WIDTH-1:0] rs2_addr;
   logic [DATA_WIDTH-1:0] rs1_data;
   logic [DATA_WIDTH-1:0] rs2_data;
   logic                  rs1_busy;
   logic                  rs2_busy;
   logic [ADDR_WIDTH:0]   pending_count;

   modport master (
      output result_in, reg_addr_in, write_enable_in, issue_valid, issue_addr,
             rs1_addr, rs2_addr,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, pending_count
   );

   modport slave (
      input  result_in, reg_addr_in, write_enable_in, issue_valid, issue_addr,
             rs1_addr, rs2_addr,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, pending_count
   );
endinterface

// File: rtl/wb_register_file.sv
// Register file with a per-register pending scoreboard and two async read ports.
// Optional WB_BYPASS_EN forwards same-cycle writeback data/busy to the read ports.
module wb_rf_read_port #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
   input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
   input  logic [NUM_REGS-1:0]                 pending,
   input  logic [ADDR_WIDTH-1:0]               addr,
   input  logic                                wb_en,
   input  logic [ADDR_WIDTH-1:0]               wb_addr,
   input  logic [DATA_WIDTH-1:0]               wb_data,
   input  logic                                iss_valid,
   input  logic [ADDR_WIDTH-1:0]               iss_addr,
   output logic [DATA_WIDTH-1:0]               data,
   output logic                                busy
);
`ifdef WB_BYPASS_EN
   logic hit;
   assign hit = wb_en && (wb_addr == addr);

   always_comb begin
      data = regs[addr];
      busy = pending[addr];
      if (addr == '0) begin
         data = '0;
         busy = 1'b0;
      end else if (hit) begin
         // writeback retires the entry now unless the same reg is reissued
         data = wb_data;
         busy = iss_valid && (iss_addr == addr);
      end
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{wb_en, wb_addr, wb_data, iss_valid, iss_addr};

   always_comb begin
      data = regs[addr];
      busy = pending[addr];
      if (addr == '0) begin
         data = '0;
         busy = 1'b0;
      end
   end
`endif
endmodule

module wb_register_file #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input logic               clk,
   input logic               reset,
   wb_register_file_if.slave bus
);
   localparam int NUM_REGS  = 2**ADDR_WIDTH;
   localparam int NUM_PORTS = 2;
   localparam int CW        = ADDR_WIDTH + 1;

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
   logic [NUM_REGS-1:0]                  pending, pending_nxt;
   logic [CW-1:0]                        count, count_nxt;
   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
   logic [NUM_PORTS-1:0]                 rd_busy;

   // clear before set so a same-edge reissue keeps the entry pending
   always_comb begin
      pending_nxt = pending;
      if (bus.write_enable_in) pending_nxt[bus.reg_addr_in] = 1'b0;
      if (bus.issue_valid) pending_nxt[bus.issue_addr] = 1'b1;
      pending_nxt[0] = 1'b0;
      count_nxt = '0;
      for (int i = 0; i < NUM_REGS; i++) count_nxt = count_nxt + CW'(pending_nxt[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs    <= '0;
         pending <= '0;
         count   <= '0;
      end else begin
         if (bus.write_enable_in && bus.reg_addr_in != '0)
            regs[bus.reg_addr_in] <= bus.result_in;
         pending <= pending_nxt;
         count   <= count_nxt;
      end
   end

   assign rd_addr = {bus.rs2_addr, bus.rs1_addr};

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
      wb_rf_read_port #(
         .DATA_WIDTH(DATA_WIDTH),
         .ADDR_WIDTH(ADDR_WIDTH),
         .NUM_REGS  (NUM_REGS)
      ) u_rd (
         .regs     (regs),
         .pending  (pending),
         .addr     (rd_addr[p]),
         .wb_en    (bus.write_enable_in),
         .wb_addr  (bus.reg_addr_in),
         .wb_data  (bus.result_in),
         .iss_valid(bus.issue_valid),
         .iss_addr (bus.issue_addr),
         .data     (rd_data[p]),
         .busy     (rd_busy[p])
      );
   end

   assign bus.rs1_data      = rd_data[0];
   assign bus.rs2_data      = rd_data[1];
   assign bus.rs1_busy      = rd_busy[0];
   assign bus.rs2_busy      = rd_busy[1];
   assign bus.pending_count = count;
endmodule

// File: tb/tb_wb_register_file.sv
// Directed + random bench for wb_register_file against an array/set-based model.
module tb_wb_register_file;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   wb_register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus();

   wb_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // model: register values plus the set of pending register numbers
   int mem [16];
   bit pend [int];

   function automatic int exp_data(input int a);
      if (a == 0) return 0;
`ifdef WB_BYPASS_EN
      if (bus.write_enable_in && int'(bus.reg_addr_in) == a) return int'(bus.result_in);
`endif
      return mem[a];
   endfunction

   function automatic int exp_busy(input int a);
      if (a == 0) return 0;
`ifdef WB_BYPASS_EN
      if (bus.write_enable_in && int'(bus.reg_addr_in) == a)
         return (bus.issue_valid && int'(bus.issue_addr) == a) ? 1 : 0;
`endif
      return pend.exists(a) ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".rs1_data"}, 32'(bus.rs1_data), 32'(exp_data(int'(bus.rs1_addr))));
      chk({tag, ".rs2_data"}, 32'(bus.rs2_data), 32'(exp_data(int'(bus.rs2_addr))));
      chk({tag, ".rs1_busy"}, 32'(bus.rs1_busy), 32'(exp_busy(int'(bus.rs1_addr))));
      chk({tag, ".rs2_busy"}, 32'(bus.rs2_busy), 32'(exp_busy(int'(bus.rs2_addr))));
      chk({tag, ".count"},    32'(bus.pending_count), 32'(pend.num()));
   endtask

   task automatic model_edge();
      int wa, ia;
      wa = int'(bus.reg_addr_in);
      ia = int'(bus.issue_addr);
      if (reset) begin
         foreach (mem[i]) mem[i] = 0;
         pend.delete();
      end else begin
         if (bus.write_enable_in && wa != 0) mem[wa] = int'(bus.result_in);
         if (bus.write_enable_in) pend.delete(wa);
         if (bus.issue_valid && ia != 0) pend[ia] = 1'b1;
      end
   endtask

   // inputs are set just after a falling edge; check, clock once, return at next falling edge
   task automatic cyc(input string tag);
      #1 chk_all(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.write_enable_in = 1'b0;
      bus.issue_valid     = 1'b0;
      bus.reg_addr_in     = '0;
      bus.issue_addr      = '0;
      bus.result_in       = '0;
   endtask

   task automatic wr(input int a, input int d);
      bus.write_enable_in = 1'b1;
      bus.reg_addr_in     = 4'(a);
      bus.result_in       = 16'(d);
   endtask

   task automatic iss(input int a);
      bus.issue_valid = 1'b1;
      bus.issue_addr  = 4'(a);
   endtask

   initial begin
      foreach (mem[i]) mem[i] = 0;
      idle();
      bus.rs1_addr = '0;
      bus.rs2_addr = '0;
      reset = 1'b1;
      @(negedge clk);
      @(posedge clk); model_edge(); @(negedge clk);
      reset = 1'b0;
      #1 chk("reset.count", 32'(bus.pending_count), 32'd0);

      // write 0xAB to r10, visible after one edge
      wr(10, 'hAB);
      cyc("w10");
      idle();
      bus.rs1_addr = 4'd10;
      #1 chk("r10_after_write", 32'(bus.rs1_data), 32'h00AB);

      // disabled writeback must not change anything
      bus.result_in = 16'hFF; bus.reg_addr_in = 4'd9;
      cyc("we0_a");
      cyc("we0_b");
      bus.rs1_addr = 4'd9; bus.rs2_addr = 4'd10;
      #1 chk("r9_unwritten", 32'(bus.rs1_data), 32'h0000);
      chk("r10_kept", 32'(bus.rs2_data), 32'h00AB);

      // register 0 is hardwired and never pending
      wr(0, 'h1234);
      cyc("w0");
      idle();
      iss(0);
      cyc("iss0");
      idle();
      bus.rs1_addr = 4'd0;
      #1 chk("r0_zero", 32'(bus.rs1_data), 32'h0);
      chk("r0_count", 32'(bus.pending_count), 32'd0);

      // scoreboard: issue 3, 5; writeback 3 with reissue of 3
      iss(3); cyc("iss3");
      idle(); iss(5); cyc("iss5");
      idle(); iss(3); wr(3, 'h33); cyc("wb3_iss3");
      idle();
      bus.rs1_addr = 4'd3; bus.rs2_addr = 4'd5;
      #1 chk("busy3", 32'(bus.rs1_busy), 32'd1);
      chk("busy5", 32'(bus.rs2_busy), 32'd1);
      chk("count2", 32'(bus.pending_count), 32'd2);
      wr(5, 'h55); cyc("wb5");
      idle();
      #1 chk("count1", 32'(bus.pending_count), 32'd1);

      // same-cycle read of a register being written
      bus.rs2_addr = 4'd7;
      wr(7, 'hBEEF);
`ifdef WB_BYPASS_EN
      #1 chk("bypass_data", 32'(bus.rs2_data), 32'hBEEF);
      chk("bypass_busy", 32'(bus.rs2_busy), 32'd0);
`else
      #1 chk("nobypass_old", 32'(bus.rs2_data), 32'h0000);
`endif
      cyc("w7");
      idle();
      #1 chk("r7_after", 32'(bus.rs2_data), 32'hBEEF);

      // reset beats a concurrent writeback and clears three pending entries
      iss(2); cyc("iss2");
      idle(); iss(4); cyc("iss4");
      idle();
      #1 chk("count3", 32'(bus.pending_count), 32'd3);
      reset = 1'b1;
      wr(2, 'h5555);
      cyc("rst_wb");
      reset = 1'b0;
      idle();
      for (int i = 0; i < 16; i++) begin
         bus.rs1_addr = 4'(i);
         bus.rs2_addr = 4'(15 - i);
         #1;
         chk($sformatf("rst_r%0d", i), 32'(bus.rs1_data), 32'h0);
         chk($sformatf("rst_b%0d", i), 32'({bus.rs1_busy, bus.rs2_busy}), 32'h0);
      end
      chk("rst_count", 32'(bus.pending_count), 32'd0);

      // randomized traffic with occasional reset
      for (int n = 0; n < 400; n++) begin
         reset               = ($urandom_range(0, 39) == 0);
         bus.write_enable_in = $urandom_range(0, 1) == 1;
         bus.reg_addr_in     = 4'($urandom_range(0, 15));
         bus.result_in       = 16'($urandom);
         bus.issue_valid     = $urandom_range(0, 2) != 0;
         bus.issue_addr      = 4'($urandom_range(0, 15));
         bus.rs1_addr        = 4'($urandom_range(0, 15));
         bus.rs2_addr        = ($urandom_range(0, 3) == 0) ? bus.rs1_addr : 4'($urandom_range(0, 15));
         cyc("rnd");
      end
      reset = 1'b0;
      idle();
      #1 chk_all("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
